// File: rtl/div_share_ctrl.sv
// Round-robin sequencer that shares one sequential restoring divider among N
// requesters; divide-by-zero is answered locally without touching the divider.
module div_share_ctrl #(
  parameter int LEN = 16,
  parameter int N   = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N-1:0]     REQ,
  input  logic [N*LEN-1:0] REQ_A,
  input  logic [N*LEN-1:0] REQ_B,
  output logic [N-1:0]     GNT,
  output logic [N-1:0]     RSP_VALID,
  output logic [LEN-1:0]   RSP_Q,
  output logic [LEN-1:0]   RSP_R,
  output logic             RSP_DZ,
  output logic             BUSY,
  output logic             DIV_START,
  output logic [LEN-1:0]   DIV_A,
  output logic [LEN-1:0]   DIV_B,
  input  logic             DIV_DONE,
  input  logic [LEN-1:0]   DIV_Q,
  input  logic [LEN-1:0]   DIV_R
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] win;
  logic [IW-1:0] ptr_nxt;
  logic [LEN-1:0] win_a;
  logic [LEN-1:0] win_b;
  logic [N-1:0]  win_oh;
  logic [N-1:0]  idx_oh;

  // Scan from the farthest candidate back to the pointer so the last hit is
  // the first set bit at or after the pointer (modulo N).
  always_comb begin
    int c;
    c   = 0;
    win = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (REQ[IW'(c)]) win = IW'(c);
    end
  end

  assign ptr_nxt = (win == IW'(N - 1)) ? '0 : win + 1'b1;
  assign win_a   = REQ_A[int'(win)*LEN +: LEN];
  assign win_b   = REQ_B[int'(win)*LEN +: LEN];
  assign win_oh  = {{(N-1){1'b0}}, 1'b1} << win;
  assign idx_oh  = {{(N-1){1'b0}}, 1'b1} << idx;

  // NOTE: state and every registered output use non-blocking assignments so
  // all updates in this block see the pre-edge values of one another.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx       <= '0;
      GNT       <= '0;
      RSP_VALID <= '0;
      RSP_Q     <= '0;
      RSP_R     <= '0;
      RSP_DZ    <= 1'b0;
      BUSY      <= 1'b0;
      DIV_START <= 1'b0;
      DIV_A     <= '0;
      DIV_B     <= '0;
    end else begin
      GNT       <= '0;
      RSP_VALID <= '0;
      DIV_START <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|REQ) begin
            DIV_A <= win_a;
            DIV_B <= win_b;
            idx   <= win;
            GNT   <= win_oh;
            ptr   <= ptr_nxt;
            BUSY  <= 1'b1;
            if (win_b == '0) begin
              RSP_Q     <= '1;
              RSP_R     <= win_a;
              RSP_DZ    <= 1'b1;
              RSP_VALID <= win_oh;
              state     <= S_RESP;
            end else begin
              DIV_START <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        // DIV_DONE is still high from the previous idle period here.
        S_ISSUE: state <= S_BUSY;
        S_BUSY: begin
          if (DIV_DONE) begin
            RSP_Q     <= DIV_Q;
            RSP_R     <= DIV_R;
            RSP_DZ    <= 1'b0;
            RSP_VALID <= idx_oh;
            state     <= S_RESP;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequencer/arbiter that shares one sequential restoring divider among N requesters.
- Arbitrates with a round-robin policy and captures the winner's operands.
- Drives the divider's START/A/B inputs, waits for DONE, then returns Q/R to the winner as a one-hot response pulse.
- Handles divide-by-zero locally, without occupying the divider.

Parameters:
- LEN, 16, operand/result width; must match the divider's LEN.
- N, 4, number of requesters (2..16); IW = max(1, $clog2(N)) is a localparam.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  N  per-requester request level.
- REQ_A  in  N*LEN  numerators, packed; requester i uses bits [i*LEN +: LEN].
- REQ_B  in  N*LEN  denominators, packed the same way.
- GNT  out  N  one-hot, one-cycle pulse; operands of that requester were captured.
- RSP_VALID  out  N  one-hot, one-cycle pulse; result for that requester is on RSP_Q/RSP_R/RSP_DZ.
- RSP_Q  out  LEN  quotient.
- RSP_R  out  LEN  remainder.
- RSP_DZ  out  1  high when the divisor was 0.
- BUSY  out  1  high in any state other than IDLE.
- DIV_START  out  1  divider start strobe.
- DIV_A  out  LEN  divider numerator (captured operand).
- DIV_B  out  LEN  divider denominator (captured operand).
- DIV_DONE  in  1  divider done level; high while the divider is idle.
- DIV_Q  in  LEN  divider quotient.
- DIV_R  in  LEN  divider remainder.

Behaviour:
- Reset (asynchronous on RST_N low, regardless of state):
  - State = IDLE; round-robin pointer = 0.
  - GNT, RSP_VALID, DIV_START = 0; RSP_Q, RSP_R, DIV_A, DIV_B = 0; RSP_DZ = 0; BUSY = 0.
- All outputs are registered. No combinational path from any input to any output.
- State machine:
  - IDLE:
    - If REQ is nonzero, pick the first set bit at or after the pointer, wrapping modulo N.
    - At that clock edge: capture REQ_A/REQ_B of the winner into DIV_A/DIV_B, record its index, set GNT[i] = 1 for the next cycle, and set pointer = (i+1) mod N.
    - If the captured B == 0, go to RESP with RSP_Q = all ones, RSP_R = A, RSP_DZ = 1; DIV_START stays 0.
    - Otherwise go to ISSUE with DIV_START = 1.
  - ISSUE:
    - DIV_START is high for exactly this one cycle.
    - DIV_DONE is ignored here (it is stale).
    - Unconditionally go to BUSY.
  - BUSY:
    - DIV_START = 0.
    - When DIV_DONE = 1, capture DIV_Q/DIV_R into RSP_Q/RSP_R, set RSP_DZ = 0, and go to RESP.
  - RESP:
    - RSP_VALID[idx] = 1 for exactly one cycle, then go to IDLE.
    - RSP_Q/RSP_R/RSP_DZ hold their values until the next capture.
- Latency (REQ sampled in IDLE cycle t, divider LEN = 16):
  - GNT in cycle t+1; DIV_START in cycle t+1; DIV_DONE first high in cycle t+LEN+2; RSP_VALID in cycle t+LEN+3; IDLE in cycle t+LEN+4.
  - Divide-by-zero: GNT and RSP_VALID both in cycle t+1; IDLE in cycle t+2.
- Requester contract:
  - Hold REQ and operands stable until GNT is seen, then drop REQ in the GNT cycle.
  - REQ still high on return to IDLE is treated as a new request.
  - Operand changes after capture have no effect.
- REQ seen outside IDLE is not acted on; no queueing.
- Fairness: after requester i is served, every other requester with REQ held high is served before i again. Worst-case wait is (N-1) operations.
- Reset mid-operation: the divider has no reset and may keep running. After RST_N rises, the controller is in IDLE and the next issue re-STARTs the divider, which overrides its state. No RSP_VALID is emitted for the aborted operation.
- Operations are unsigned. Widths are exactly LEN; no truncation beyond the divider's own.

Test Plan:
- Single request: REQ=4'b0010, A=100, B=7 -> GNT=0010 at t+1, DIV_START pulse at t+1, RSP_VALID=0010 at t+19 with Q=14, R=2, DZ=0.
- Divide by zero: REQ=0001, A=0x1234, B=0 -> GNT and RSP_VALID=0001 both at t+1, Q=0xFFFF, R=0x1234, DZ=1, DIV_START never asserted.
- Round-robin: REQ=1111 held (each requester re-raises after its response) -> grant order 0,1,2,3,0; REQ=1001 with pointer=1 -> grant 3, then 0.
- Boundary values: A=0xFFFF, B=1 -> Q=0xFFFF, R=0; A=5, B=9 -> Q=0, R=5; A=0xFFFF, B=0xFFFF -> Q=1, R=0.
- Reset mid-BUSY: assert RST_N low at t+8 for 2 cycles -> all outputs 0 immediately, no RSP_VALID; a new request A=50, B=6 after release -> Q=8, R=2 with normal latency.
- Operand churn: change REQ_A/REQ_B and keep REQ high in the cycle after GNT -> response uses the captured operands; a second operation is granted only after RESP.
